// File: rtl/gaussian_ctrl_pkg.sv
// Shared types and constants for the two-pass 3-tap Gaussian address sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gaussian_ctrl_pkg;

  localparam int DEF_WIDTH  = 256;
  localparam int DEF_HEIGHT = 256;
  localparam int DEF_ADDR_W = 21;

  // Pass select: H reads buffer 1 / writes buffer 2, V reads buffer 2 / writes buffer 1
  localparam logic PASS_H = 1'b0;
  localparam logic PASS_V = 1'b1;

  // Tap index within a pixel: previous neighbour, centre, next neighbour
  localparam logic [1:0] TAP_PREV = 2'd0;
  localparam logic [1:0] TAP_CTR  = 2'd1;
  localparam logic [1:0] TAP_NEXT = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_FIN  = 3'd3,
    S_HALT = 3'd4
  } state_t;

endpackage

// File: rtl/gaussian_addr_gen.sv
// Maps (pass, tap, row, col) to the border-clamped read address and the write address.
// Latency: purely combinational.
// Backpressure: none; addresses follow the inputs directly.
module gaussian_addr_gen
  import gaussian_ctrl_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              i_pass,
  input  logic [1:0]        i_tap,
  input  logic [ADDR_W-1:0] i_row,
  input  logic [ADDR_W-1:0] i_col,
  output logic [ADDR_W-1:0] o_raddr,
  output logic [ADDR_W-1:0] o_waddr
);

  logic [ADDR_W-1:0] w_row;
  logic [ADDR_W-1:0] w_col;

  // Neighbour offset along the pass direction, replicating the border pixel at the edges
  always_comb begin
    w_row = i_row;
    w_col = i_col;
    if (i_pass == PASS_H) begin
      if (i_tap == TAP_PREV && i_col != '0)
        w_col = i_col - ADDR_W'(1);
      else if (i_tap == TAP_NEXT && i_col != ADDR_W'(WIDTH - 1))
        w_col = i_col + ADDR_W'(1);
    end else begin
      if (i_tap == TAP_PREV && i_row != '0)
        w_row = i_row - ADDR_W'(1);
      else if (i_tap == TAP_NEXT && i_row != ADDR_W'(HEIGHT - 1))
        w_row = i_row + ADDR_W'(1);
    end
    o_raddr = w_row * ADDR_W'(WIDTH) + w_col;
    o_waddr = i_row * ADDR_W'(WIDTH) + i_col;
  end

endmodule

// File: rtl/gaussian_ctrl.sv
// Two-pass separable blur sequencer: 3 reads + 1 write per pixel, H pass then V pass, then writefile.
// Latency: first read the edge after rst drops; writefile at edge 8*WIDTH*HEIGHT+1.
// Backpressure: none; the external memories and datapath must keep up every cycle.
module gaussian_ctrl
  import gaussian_ctrl_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] raddr,
  output logic [ADDR_W-1:0] waddr,
  output logic              ren1,
  output logic              wen1,
  output logic              ren2,
  output logic              wen2,
  output logic              writefile
);

  state_t            r_state;
  state_t            w_state_nx;
  logic              r_pass;
  logic              w_pass_nx;
  logic [1:0]        r_tap;
  logic [1:0]        w_tap_nx;
  logic [ADDR_W-1:0] r_row;
  logic [ADDR_W-1:0] w_row_nx;
  logic [ADDR_W-1:0] r_col;
  logic [ADDR_W-1:0] w_col_nx;
  logic [ADDR_W-1:0] r_raddr_hold;
  logic [ADDR_W-1:0] r_waddr_hold;
  logic [ADDR_W-1:0] w_gen_raddr;
  logic [ADDR_W-1:0] w_gen_waddr;
  logic              w_last_col;
  logic              w_last_pix;

  gaussian_addr_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .i_pass  (r_pass),
    .i_tap   (r_tap),
    .i_row   (r_row),
    .i_col   (r_col),
    .o_raddr (w_gen_raddr),
    .o_waddr (w_gen_waddr)
  );

  assign w_last_col = (r_col == ADDR_W'(WIDTH - 1));
  assign w_last_pix = w_last_col && (r_row == ADDR_W'(HEIGHT - 1));

  // State, scan counters and held addresses; reset returns everything to the pre-run values
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pass       <= PASS_H;
      r_tap        <= TAP_PREV;
      r_row        <= '0;
      r_col        <= '0;
      r_raddr_hold <= '0;
      r_waddr_hold <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_pass       <= w_pass_nx;
      r_tap        <= w_tap_nx;
      r_row        <= w_row_nx;
      r_col        <= w_col_nx;
      r_raddr_hold <= raddr;
      r_waddr_hold <= waddr;
    end
  end

  // Next state: three tap reads then a write per pixel, row-major, H pass rolls straight into V
  always_comb begin
    w_state_nx = r_state;
    w_pass_nx  = r_pass;
    w_tap_nx   = r_tap;
    w_row_nx   = r_row;
    w_col_nx   = r_col;
    case (r_state)
      S_IDLE: begin
        w_state_nx = S_RD;
        w_tap_nx   = TAP_PREV;
      end
      S_RD: begin
        if (r_tap == TAP_NEXT) w_state_nx = S_WR;
        else                   w_tap_nx   = r_tap + 2'd1;
      end
      S_WR: begin
        w_tap_nx = TAP_PREV;
        if (w_last_pix) begin
          w_row_nx = '0;
          w_col_nx = '0;
          if (r_pass == PASS_H) begin
            w_pass_nx  = PASS_V;
            w_state_nx = S_RD;
          end else begin
            w_state_nx = S_FIN;
          end
        end else begin
          w_state_nx = S_RD;
          if (w_last_col) begin
            w_col_nx = '0;
            w_row_nx = r_row + ADDR_W'(1);
          end else begin
            w_col_nx = r_col + ADDR_W'(1);
          end
        end
      end
      S_FIN:   w_state_nx = S_HALT;
      S_HALT:  w_state_nx = S_HALT;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Moore output decode; addresses hold their last value while their enable is low
  always_comb begin
    ren1      = (r_state == S_RD) && (r_pass == PASS_H);
    ren2      = (r_state == S_RD) && (r_pass == PASS_V);
    wen2      = (r_state == S_WR) && (r_pass == PASS_H);
    wen1      = (r_state == S_WR) && (r_pass == PASS_V);
    writefile = (r_state == S_FIN);
    raddr     = (r_state == S_RD) ? w_gen_raddr : r_raddr_hold;
    waddr     = (r_state == S_WR) ? w_gen_waddr : r_waddr_hold;
  end

endmodule

// File: tb/tb_gaussian_ctrl.sv
// Bench for gaussian_ctrl at 4x3: reference model indexed by cycles since reset release.
// Latency: n/a.
// Backpressure: n/a.
module tb_gaussian_ctrl;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int AW   = 21;
  localparam int NPIX = W * H;
  localparam int KFIN = 8 * NPIX + 1;

  logic          clk;
  logic          rst;
  logic [AW-1:0] raddr;
  logic [AW-1:0] waddr;
  logic          ren1, wen1, ren2, wen2, writefile;

  gaussian_ctrl #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .raddr     (raddr),
    .waddr     (waddr),
    .ren1      (ren1),
    .wen1      (wen1),
    .ren2      (ren2),
    .wen2      (wen2),
    .writefile (writefile)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: k = edges sampled with rst low since the last edge sampled with rst high
  int k = 0;
  bit m_valid = 1'b0;
  int m_raddr, m_waddr;
  int m_ren1, m_wen1, m_ren2, m_wen2, m_wf;
  int c_ren1, c_wen1, c_ren2, c_wen2;

  // Hand-computed pins for the 4x3 image
  int lit_rk[18] = '{1, 2, 3, 13, 14, 15, 21, 22, 23, 49, 50, 51, 85, 86, 87, 93, 94, 95};
  int lit_ra[18] = '{0, 0, 1,  2,  3,  3,  4,  5,  6,  0,  0,  4,  5,  9,  9,  7, 11, 11};
  int lit_wk[5]  = '{4, 16, 24, 52, 88};
  int lit_wa[5]  = '{0,  3,  5,  0,  9};

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s k=%0d got=%0d want=%0d", name, k, act, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // Expected outputs for cycle k, straight from the scan arithmetic
  task automatic model_eval(input int kk);
    int idx, pass, w, pix, slot, r, c, rr, cc;
    m_ren1 = 0; m_wen1 = 0; m_ren2 = 0; m_wen2 = 0; m_wf = 0;
    if (kk >= 1 && kk <= 8 * NPIX) begin
      idx  = kk - 1;
      pass = idx / (4 * NPIX);
      w    = idx % (4 * NPIX);
      pix  = w / 4;
      slot = w % 4;
      r    = pix / W;
      c    = pix % W;
      if (slot < 3) begin
        rr = r;
        cc = c;
        if (pass == 0) cc = clampi(c + slot - 1, 0, W - 1);
        else           rr = clampi(r + slot - 1, 0, H - 1);
        m_raddr = rr * W + cc;
        if (pass == 0) m_ren1 = 1; else m_ren2 = 1;
      end else begin
        m_waddr = pix;
        if (pass == 0) m_wen2 = 1; else m_wen1 = 1;
      end
    end else if (kk == KFIN) begin
      m_wf = 1;
    end
  endtask

  // Advance the model on every rising edge using the rst value the DUT samples
  always @(posedge clk) begin
    if (rst) begin
      k = 0;
      m_valid = 1'b1;
      m_raddr = 0;
      m_waddr = 0;
      c_ren1 = 0; c_wen1 = 0; c_ren2 = 0; c_wen2 = 0;
    end else if (m_valid) begin
      k++;
    end
    if (m_valid) model_eval(k);
  end

  // Compare every cycle on the falling edge
  always @(negedge clk) begin
    if (m_valid) begin
      check("ren1", int'(ren1), m_ren1);
      check("wen1", int'(wen1), m_wen1);
      check("ren2", int'(ren2), m_ren2);
      check("wen2", int'(wen2), m_wen2);
      check("writefile", int'(writefile), m_wf);
      check("raddr", int'(raddr), m_raddr);
      check("waddr", int'(waddr), m_waddr);
      check("onehot", int'((int'(ren1) + int'(wen1) + int'(ren2) + int'(wen2)) <= 1), 1);
      if (k == 0) begin
        check("rst_raddr0", int'(raddr), 0);
        check("rst_waddr0", int'(waddr), 0);
      end
      for (int i = 0; i < 18; i++)
        if (k == lit_rk[i]) begin
          check("lit_raddr", int'(raddr), lit_ra[i]);
          check("lit_ren", int'(k < 49 ? ren1 : ren2), 1);
        end
      for (int i = 0; i < 5; i++)
        if (k == lit_wk[i]) begin
          check("lit_waddr", int'(waddr), lit_wa[i]);
          check("lit_wen", int'(k < 49 ? wen2 : wen1), 1);
        end
      if (k == KFIN) begin
        check("lit_wf97", int'(writefile), 1);
        check("cnt_ren1", c_ren1, 36);
        check("cnt_wen2", c_wen2, 12);
        check("cnt_ren2", c_ren2, 36);
        check("cnt_wen1", c_wen1, 12);
      end
      c_ren1 += int'(ren1);
      c_wen1 += int'(wen1);
      c_ren2 += int'(ren2);
      c_wen2 += int'(wen2);
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    // Run into pass V, pixel 6, tap 1, then reset for one edge
    for (int i = 0; i < 200 && k != 74; i++) @(negedge clk);
    check("wait_k74", k, 74);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    // Full run to completion plus the quiet tail
    repeat (210) @(negedge clk);
    // Random reset storms
    for (int it = 0; it < 6; it++) begin
      repeat ($urandom_range(1, 120)) @(negedge clk);
      rst = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst = 1'b0;
    end
    repeat (210) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
